// File: rtl/fpadd_special_resolve_pkg.sv
// Shared widths, constants and stage bundles for the FP-add special-case resolver.
// The `defines mirror constants.v so the block builds standalone.
`ifndef WIDTH
`define WIDTH 32
`endif
`ifndef WSIG
`define WSIG 23
`endif
`ifndef QNAN_DEFAULT
`define QNAN_DEFAULT 32'h7FC00000
`endif

package fpadd_special_resolve_pkg;

    localparam int WIDTH = `WIDTH;
    localparam int WSIG  = `WSIG;
    localparam int WEXP  = WIDTH - 1 - WSIG;

    localparam logic [WIDTH-1:0] QNAN_DEFAULT = `QNAN_DEFAULT;

    typedef struct packed {
        logic             a_sign;
        logic             b_sign;
        logic             op_sub;
        logic [WIDTH-2:0] a;
        logic [WIDTH-2:0] b;
        logic             ainf;
        logic             binf;
        logic             anan;
        logic             bnan;
        logic             asignan;
        logic             bsignan;
        logic             specinput;
    } s1_t;

    typedef struct packed {
        logic             special;
        logic [WIDTH-1:0] result;
        logic             invalid;
    } s2_t;

    // Force the significand MSB so a signalling NaN leaves as a quiet one.
    function automatic logic [WIDTH-2:0] quiet(
        input logic [WIDTH-2:0] f
    );
        logic [WIDTH-2:0] m;
        m = '0;
        m[WSIG-1] = 1'b1;
        return f | m;
    endfunction

    function automatic logic [WIDTH-1:0] inf_of(
        input logic s
    );
        return {s, {WEXP{1'b1}}, {WSIG{1'b0}}};
    endfunction

endpackage

// File: rtl/fpadd_special_resolve_fp_pipe_stage.sv
// Generic valid/ready register slice; accepts when empty or
// when its content is drained in the same cycle.
module fp_pipe_stage #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    assign in_ready = ~out_valid | out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (in_ready) begin
            out_valid <= in_valid;
            if (in_valid) begin
                out_data <= in_data;
            end
        end
    end

endmodule

// File: rtl/fpadd_special_resolve.sv
// Two-stage resolver for NaN/infinity operands of an FP adder,
// with a sticky invalid-operation flag.
module fpadd_special_resolve
    import fpadd_special_resolve_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             a_sign,
    input  logic             b_sign,
    input  logic             op_sub,
    input  logic [WIDTH-2:0] a,
    input  logic [WIDTH-2:0] b,
    input  logic             ainf,
    input  logic             binf,
    input  logic             anan,
    input  logic             bnan,
    input  logic             asignan,
    input  logic             bsignan,
    input  logic             specinput,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_special,
    output logic [WIDTH-1:0] out_result,
    output logic             out_invalid,
    input  logic             flag_clr,
    output logic             invalid_sticky
);

    s1_t  s1_d;
    s1_t  s1_q;
    s2_t  s2_d;
    s2_t  s2_q;
    logic s1_valid;
    logic s2_ready;
    logic inf_sub;

    logic [WIDTH-1:0] res;

    assign s1_d = '{
        a_sign:    a_sign,
        b_sign:    b_sign,
        op_sub:    op_sub,
        a:         a,
        b:         b,
        ainf:      ainf,
        binf:      binf,
        anan:      anan,
        bnan:      bnan,
        asignan:   asignan,
        bsignan:   bsignan,
        specinput: specinput
    };

    fp_pipe_stage #(
        .W($bits(s1_t))
    ) u_s1 (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (s1_d),
        .out_valid(s1_valid),
        .out_ready(s2_ready),
        .out_data (s1_q)
    );

    // First matching case wins: NaNs, then inf-inf, then single infinities.
    always_comb begin
        s2_d    = '0;
        res     = '0;
        inf_sub = s1_q.ainf & s1_q.binf
                & (s1_q.a_sign ^ s1_q.b_sign ^ s1_q.op_sub);
        priority case (1'b1)
            s1_q.anan: res = {s1_q.a_sign, quiet(s1_q.a)};
            s1_q.bnan: res = {s1_q.b_sign, quiet(s1_q.b)};
            inf_sub:   res = QNAN_DEFAULT;
            s1_q.ainf: res = inf_of(s1_q.a_sign);
            s1_q.binf: res = inf_of(s1_q.b_sign ^ s1_q.op_sub);
            default:   res = '0;
        endcase
        s2_d.special = s1_q.specinput;
        s2_d.result  = s1_q.specinput ? res : '0;
        s2_d.invalid = s1_q.asignan | s1_q.bsignan | inf_sub;
    end

    fp_pipe_stage #(
        .W($bits(s2_t))
    ) u_s2 (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (s1_valid),
        .in_ready (s2_ready),
        .in_data  (s2_d),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (s2_q)
    );

    assign out_special = s2_q.special;
    assign out_result  = s2_q.result;
    assign out_invalid = s2_q.invalid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            invalid_sticky <= 1'b0;
        end else if (out_valid & out_ready & out_invalid) begin
            invalid_sticky <= 1'b1;
        end else if (flag_clr) begin
            invalid_sticky <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fpadd_special_resolve.sv
// Directed bench for fpadd_special_resolve with an in-bench
// IEEE-level model and a per-cycle output checker.
module tb_fpadd_special_resolve;
    import fpadd_special_resolve_pkg::*;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic             a_sign = 1'b0;
    logic             b_sign = 1'b0;
    logic             op_sub = 1'b0;
    logic [WIDTH-2:0] a = '0;
    logic [WIDTH-2:0] b = '0;
    logic             ainf = 1'b0;
    logic             binf = 1'b0;
    logic             anan = 1'b0;
    logic             bnan = 1'b0;
    logic             asignan = 1'b0;
    logic             bsignan = 1'b0;
    logic             specinput = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic             out_special;
    logic [WIDTH-1:0] out_result;
    logic             out_invalid;
    logic             flag_clr = 1'b0;
    logic             invalid_sticky;

    fpadd_special_resolve dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .a_sign        (a_sign),
        .b_sign        (b_sign),
        .op_sub        (op_sub),
        .a             (a),
        .b             (b),
        .ainf          (ainf),
        .binf          (binf),
        .anan          (anan),
        .bnan          (bnan),
        .asignan       (asignan),
        .bsignan       (bsignan),
        .specinput     (specinput),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_special   (out_special),
        .out_result    (out_result),
        .out_invalid   (out_invalid),
        .flag_clr      (flag_clr),
        .invalid_sticky(invalid_sticky)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int nrecv = 0;
    int acc_cyc = 0;
    bit exp_sticky = 1'b0;
    bit hold_v = 1'b0;
    bit seen_block = 1'b0;
    logic [35:0] held;
    logic [33:0] q[$];
    int rcyc[$];

    always @(posedge clk) cyc++;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Expected {special, result, invalid} straight from IEEE-754 semantics.
    function automatic logic [33:0] model(input logic [31:0] wa,
                                          input logic [31:0] wb,
                                          input logic op);
        logic xa, xb, na, nb, ia, ib, sa, sb, sbe, spec, inv;
        logic [31:0] r;
        xa  = (wa[30:23] == 8'hFF);
        xb  = (wb[30:23] == 8'hFF);
        na  = xa && (wa[22:0] != 0);
        nb  = xb && (wb[22:0] != 0);
        ia  = xa && (wa[22:0] == 0);
        ib  = xb && (wb[22:0] == 0);
        sa  = na && !wa[22];
        sb  = nb && !wb[22];
        sbe = wb[31] ^ op;
        spec = na | nb | ia | ib;
        inv = sa | sb;
        if (na) r = wa | 32'h0040_0000;
        else if (nb) r = wb | 32'h0040_0000;
        else if (ia && ib && (wa[31] != sbe)) begin
            r = 32'h7FC0_0000;
            inv = 1'b1;
        end
        else if (ia) r = wa;
        else if (ib) r = {sbe, wb[30:0]};
        else r = 32'h0;
        return {spec, r, inv};
    endfunction

    always @(negedge clk) begin
        logic [33:0] e;
        if (!rst_n) begin
            q.delete();
            exp_sticky = 1'b0;
            hold_v = 1'b0;
        end else begin
            chk("sticky", invalid_sticky, exp_sticky);
            if (hold_v)
                chk("stall_hold",
                    {out_valid, out_special, out_result, out_invalid},
                    held);
            if (in_valid && !in_ready) seen_block = 1'b1;
            e = '0;
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    chk("extra_output", 1, 0);
                end else begin
                    e = q.pop_front();
                    chk("out", {out_special, out_result, out_invalid}, e);
                    rcyc.push_back(cyc);
                    nrecv++;
                end
            end
            hold_v = out_valid && !out_ready;
            held = {out_valid, out_special, out_result, out_invalid};
            if (out_valid && out_ready && e[0]) exp_sticky = 1'b1;
            else if (flag_clr) exp_sticky = 1'b0;
        end
    end

    task automatic send(input logic [31:0] wa, input logic [31:0] wb,
                        input logic op);
        int n;
        a_sign    = wa[31];
        b_sign    = wb[31];
        a         = wa[30:0];
        b         = wb[30:0];
        op_sub    = op;
        ainf      = (wa[30:23] == 8'hFF) && (wa[22:0] == 0);
        binf      = (wb[30:23] == 8'hFF) && (wb[22:0] == 0);
        anan      = (wa[30:23] == 8'hFF) && (wa[22:0] != 0);
        bnan      = (wb[30:23] == 8'hFF) && (wb[22:0] != 0);
        asignan   = anan && !wa[22];
        bsignan   = bnan && !wb[22];
        specinput = ainf | binf | anan | bnan;
        in_valid  = 1'b1;
        n = 0;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            n++;
            if (n > 50) begin
                chk("in_ready_timeout", 0, 1);
                break;
            end
        end
        q.push_back(model(wa, wb, op));
        acc_cyc = cyc;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic one(input logic [31:0] wa, input logic [31:0] wb,
                       input logic op, input logic [31:0] er,
                       input logic ei, input logic es, input logic clr);
        int n;
        send(wa, wb, op);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!out_valid && n < 20);
        chk("out_valid_seen", out_valid, 1);
        chk("latency", cyc - acc_cyc, 2);
        chk("lit_result", out_result, er);
        chk("lit_invalid", out_invalid, ei);
        chk("lit_special", out_special, es);
        flag_clr = clr;
        @(posedge clk);
        #1 flag_clr = 1'b0;
    endtask

    logic [31:0] sa_v[6] = '{32'h7F800000, 32'h3F800000, 32'h7F800001,
                             32'hFF800000, 32'h40000000, 32'h3F800000};
    logic [31:0] sb_v[6] = '{32'h7F800000, 32'hFFC00003, 32'h3F800000,
                             32'h3F800000, 32'h7F800000, 32'h40400000};
    logic        so_v[6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_result", out_result, 0);
        chk("rst_out_special", out_special, 0);
        chk("rst_sticky", invalid_sticky, 0);
        rst_n = 1'b1;
        out_ready = 1'b1;

        chk("model_infsub", model(32'h7F800000, 32'h7F800000, 1),
            {1'b1, 32'h7FC00000, 1'b1});
        chk("model_snan", model(32'h7F800001, 32'h3F800000, 0),
            {1'b1, 32'h7FC00001, 1'b1});
        chk("model_neg_binf", model(32'h3F800000, 32'hFF800000, 1),
            {1'b1, 32'h7F800000, 1'b0});
        chk("model_normal", model(32'h3F800000, 32'h40000000, 0),
            {1'b0, 32'h0, 1'b0});

        one(32'h7F800000, 32'h7F800000, 1, 32'h7FC00000, 1, 1, 0);
        chk("sticky_after_inv", invalid_sticky, 1);
        one(32'h7F800001, 32'h3F800000, 0, 32'h7FC00001, 1, 1, 0);
        one(32'h7FC00005, 32'h3F800000, 0, 32'h7FC00005, 0, 1, 0);
        one(32'h3F800000, 32'hFF800000, 1, 32'h7F800000, 0, 1, 0);
        one(32'h3F800000, 32'h40000000, 0, 32'h00000000, 0, 0, 0);
        one(32'h3F800000, 32'hFF800002, 1, 32'hFFC00002, 1, 1, 0);
        one(32'hFF800000, 32'h7F800000, 0, 32'h7FC00000, 1, 1, 0);
        one(32'hFF800000, 32'h3F800000, 0, 32'hFF800000, 0, 1, 0);
        one(32'h7F800000, 32'hFF800000, 1, 32'h7F800000, 0, 1, 0);

        nrecv = 0;
        rcyc.delete();
        seen_block = 1'b0;
        fork
            begin
                for (int i = 0; i < 6; i++) send(sa_v[i], sb_v[i], so_v[i]);
            end
            begin
                out_ready = 1'b1;
                repeat (2) @(posedge clk);
                #1 out_ready = 1'b0;
                repeat (3) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        repeat (10) @(posedge clk);
        #1;
        chk("stream_count", nrecv, 6);
        chk("stream_leftover", q.size(), 0);
        chk("stream_blocked", seen_block, 1);
        if (rcyc.size() >= 3) begin
            chk("stream_rate1", rcyc[rcyc.size()-1] - rcyc[rcyc.size()-2], 1);
            chk("stream_rate2", rcyc[rcyc.size()-2] - rcyc[rcyc.size()-3], 1);
        end else begin
            chk("stream_rcyc", rcyc.size(), 3);
        end

        out_ready = 1'b0;
        send(32'h7F800000, 32'h3F800000, 0);
        send(32'h3F800000, 32'h7F800000, 1);
        chk("full_in_ready", in_ready, 0);
        chk("pre_rst_sticky", invalid_sticky, 1);
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_out_result", out_result, 0);
        chk("mid_rst_special", out_special, 0);
        chk("mid_rst_invalid", out_invalid, 0);
        chk("mid_rst_sticky", invalid_sticky, 0);
        chk("mid_rst_in_ready", in_ready, 1);
        @(posedge clk);
        #1 rst_n = 1'b1;
        out_ready = 1'b1;
        chk("post_rst_in_ready", in_ready, 1);
        one(32'hFF800000, 32'h3F800000, 1, 32'hFF800000, 0, 1, 0);
        chk("post_rst_q", q.size(), 0);

        one(32'h7F800000, 32'h7F800000, 1, 32'h7FC00000, 1, 1, 1);
        chk("clr_vs_set", invalid_sticky, 1);
        flag_clr = 1'b1;
        @(posedge clk);
        #1 flag_clr = 1'b0;
        chk("clr_alone", invalid_sticky, 0);

        repeat (2) @(posedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fpadd_special_resolve.md
FPADD_SPECIAL_RESOLVE -- requirements
Module: fpadd_special_resolve

Interface
REQ-001 WIDTH, `WIDTH (32), total FP word width including sign, from constants.v.
REQ-002 WSIG, `WSIG (23), significand field width, from constants.v.
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-004 clk  in  1  sole clock; all state updates on the rising edge.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 in_valid  in  1  operand set and classifier flags valid.
REQ-007 in_ready  out  1  block accepts the input this cycle.
REQ-008 a_sign, b_sign  in  1 each  operand signs.
REQ-009 op_sub  in  1  1 = subtract (b sign effectively inverted).
REQ-010 a, b  in  WIDTH-1 each  operand magnitude fields {exp, sig}.
REQ-011 ainf, binf, anan, bnan, asignan, bsignan, specinput  in  1 each  classifier flags for a and b.
REQ-012 out_valid  out  1  resolved result valid.
REQ-013 out_ready  in  1  consumer accepts the result.
REQ-014 out_special  out  1  result is a special case; the normal adder path is to be overridden.
REQ-015 out_result  out  WIDTH  resolved special result; zero when out_special=0.
REQ-016 out_invalid  out  1  IEEE invalid-operation flag for this result.
REQ-017 flag_clr  in  1  clears the sticky flag.
REQ-018 invalid_sticky  out  1  accumulated invalid flag.

Function
REQ-019 The block SHALL be a 2-stage pipeline. S1 registers the inputs. S2 registers the resolved result. Latency from input handshake to out_valid is 2 cycles; throughput is 1 result per cycle.
REQ-020 Transfer SHALL occur on valid&ready at each port. in_ready = ~s1_valid | ~s2_valid | out_ready. Each stage advances only when its downstream stage is empty or being drained in the same cycle.
REQ-021 With out_valid=1 and out_ready=0, out_* SHALL hold stable and no data SHALL be lost or duplicated.
REQ-022 Resolution priority, computed from the S1 contents:
  - a NaN: result = a_sign, a field with sig MSB forced to 1 (quieted).
  - else b NaN: result = b_sign, b field quieted.
  - else ainf & binf & (a_sign^b_sign^op_sub): result = default QNaN 0x7FC00000 (sign 0, exp all ones, sig MSB only).
  - else ainf: result = a_sign infinity.
  - else binf: result = (b_sign^op_sub) infinity.
  - else: out_special=0, out_result=0.
REQ-023 out_invalid SHALL be 1 iff asignan | bsignan | (inf-minus-inf case of REQ-022).
REQ-024 out_special SHALL equal the registered specinput.
REQ-025 invalid_sticky SHALL set on an output transfer with out_invalid=1, and clear on flag_clr. If both occur in the same cycle, set wins. flag_clr is independent of the handshakes.

Reset
REQ-026 While rst_n=0, the block SHALL hold s1_valid=0, s2_valid=0, out_valid=0, out_special=0, out_result=0, out_invalid=0 and invalid_sticky=0; in_ready=1 takes effect immediately.
REQ-027 Reset asserted mid-operation SHALL discard all in-flight entries. The first cycle after deassertion SHALL accept new input.

Structure
REQ-028 `WIDTH, `WSIG and a new `QNAN_DEFAULT SHALL be defined in constants.v. No local magic constants are permitted.
REQ-029 One sub-module, fp_pipe_stage, SHALL be used: a parameterised valid/ready register stage instantiated twice. The resolution logic stays inline.

Verification
REQ-030 a=+inf (0x7F800000), b=+inf, op_sub=1 -> 2 cycles later out_result=0x7FC00000, out_special=1, out_invalid=1; invalid_sticky=1 after the transfer.
REQ-031 a=sNaN 0x7F800001, b=1.0 (0x3F800000), op_sub=0 -> out_result=0x7FC00001, out_invalid=1. The same test with a=qNaN 0x7FC00005 -> 0x7FC00005, out_invalid=0.
REQ-032 a=1.0, b=-inf (0xFF800000), op_sub=1 -> out_result=0x7F800000, out_invalid=0. a=1.0, b=2.0 -> out_special=0, out_result=0.
REQ-033 Stream 6 back-to-back inputs with out_ready low for cycles 3-5 -> in_ready drops once both stages are full, out_* are stable while stalled, all 6 results emerge in order with none lost or duplicated, and the stream returns to 1 per cycle after release.
REQ-034 Pulse rst_n low with both stages full -> all outputs zero, the sticky flag cleared, and the next accepted input appears 2 cycles after acceptance.
REQ-035 flag_clr=1 in the same cycle as an invalid result transfers -> invalid_sticky=1. flag_clr alone on the next cycle -> invalid_sticky=0.
